// File: rtl/irq_ctrl_multi.sv
// rtl/irq_ctrl_multi.sv - multi-channel synchronised, debounced, mode-selectable interrupt controller
module irq_ctrl_multi #(
  parameter  int NUM_CH      = 4,
  parameter  int CLK_FREQ_HZ = 100_000_000,
  parameter  int DEBOUNCE_MS = 1,
  localparam int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_CH-1:0]     irq_in,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [2*NUM_CH-1:0]   ch_mode,
  input  logic [NUM_CH-1:0]     pend_clr,
  output logic [NUM_CH-1:0]     irq_pending,
  output logic [NUM_CH-1:0]     irq_pulse,
  output logic                  irq_out,
  output logic [ID_W-1:0]       irq_id
);

  localparam int DEBOUNCE_COUNT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int CNT_W          = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_COUNT);

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_stable;
  logic [NUM_CH-1:0] r_stable_d1;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_pulse;
  logic              r_out;
  logic [ID_W-1:0]   r_id;

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_event;
  logic [NUM_CH-1:0] w_masked;
  logic [ID_W-1:0]   w_id;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_COUNT+1 consecutive differing samples
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stable    <= '0;
      r_stable_d1 <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable_d1 <= r_stable;
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise = r_stable & ~r_stable_d1;
  assign w_fall = ~r_stable & r_stable_d1;

  always_comb begin
    w_event = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (ch_mode[2*i +: 2])
        MODE_RISE:  w_event[i] = w_rise[i];
        MODE_FALL:  w_event[i] = w_fall[i];
        MODE_BOTH:  w_event[i] = w_rise[i] | w_fall[i];
        MODE_LEVEL: w_event[i] = r_stable[i];
        default:    w_event[i] = 1'b0;
      endcase
    end
  end

  assign w_masked = r_pending & ch_enable;

  // Scan downwards so the lowest active index is the last one written
  always_comb begin
    w_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= '0;
      r_pulse   <= '0;
      r_out     <= 1'b0;
      r_id      <= '0;
    end else begin
      r_pending <= (r_pending & ~pend_clr) | (w_event & ch_enable);
      r_pulse   <= w_event & ch_enable;
      r_out     <= |w_masked;
      r_id      <= w_id;
    end
  end

  assign irq_pending = r_pending;
  assign irq_pulse   = r_pulse;
  assign irq_out     = r_out;
  assign irq_id      = r_id;

endmodule
